board_reset_ctrl: RTL
=====================

Name: board_reset_ctrl

Overview:
Board-level startup and button front-end placed beside the PLL in the iCEbreaker top level, running in the PLL output clock domain. Filters the PLL lock signal and sequences a clean synchronous system reset for the pipelinec_top instance. Synchronises and debounces N active-low pushbuttons, and can turn a long press on button 0 into a soft reset. Drives a heartbeat/status LED so board bring-up is visible without a UART.

Parameters:
- N_BTN, 1, number of active-low button inputs (1..8)
- DEBOUNCE_CYC, 120000, cycles an input must stay stable before the debounced level changes (10 ms at 12 MHz)
- LOCK_FILTER_CYC, 1024, consecutive cycles pll_locked must be high before the hold phase starts
- RST_HOLD_CYC, 16, cycles sys_rst stays asserted after the lock filter passes
- LONG_PRESS_CYC, 24000000, debounced button 0 held this long triggers a soft reset; 0 disables the feature
- HB_DIV, 6000000, heartbeat LED half-period in cycles while in RUN

Ports:
- clk, in, 1, PLL output clock
- rst, in, 1, asynchronous active-high reset
- pll_locked, in, 1, raw PLL lock, asynchronous to clk
- btn_n, in, N_BTN, raw active-low buttons, asynchronous
- sys_rst, out, 1, synchronous active-high reset for downstream logic
- btn_level, out, N_BTN, debounced level, 1 = pressed
- btn_press, out, N_BTN, one-cycle pulse on debounced press
- btn_release, out, N_BTN, one-cycle pulse on debounced release
- led_status_n, out, 1, active-low status LED
- state, out, 2, current FSM state: 0=WAIT_LOCK, 1=HOLD, 2=RUN, 3=SOFT

Behaviour:
- Reset is asynchronous and active-high; the clock is a single clk domain.
- Values during rst: sys_rst=1, btn_level=0, btn_press=0, btn_release=0, led_status_n=1 (off), state=WAIT_LOCK. All counters are 0 and all synchroniser flops hold the released state (btn_n=1, locked=0).
- Synchronisers:
  - pll_locked and each btn_n bit pass through a 2-flop synchroniser.
  - Sampled values are therefore 2 cycles late.
- Debounce, per bit:
  - Compare the synchronised input with btn_level.
  - If they differ, increment that bit's counter. If they are equal, clear the counter.
  - When the counter reaches DEBOUNCE_CYC-1 while the values still differ, update btn_level on the next edge and clear the counter.
  - btn_press / btn_release are registered edge pulses of btn_level, exactly 1 cycle wide, coincident with the btn_level change.
  - A glitch shorter than DEBOUNCE_CYC produces no change.
- Counter widths are $clog2(max+1) of each parameter. Counters saturate and never wrap.
- FSM:
  - WAIT_LOCK:
    - Asserts sys_rst.
    - lock_cnt increments while synchronised lock=1 and clears on lock=0.
    - On lock_cnt = LOCK_FILTER_CYC-1 with lock still 1, go to HOLD.
  - HOLD:
    - Asserts sys_rst for exactly RST_HOLD_CYC cycles, then goes to RUN.
    - A lock drop returns to WAIT_LOCK.
  - RUN:
    - sys_rst=0.
    - A lock drop goes to WAIT_LOCK, and sys_rst rises on the next edge.
    - If LONG_PRESS_CYC>0 and btn_level[0] has stayed 1 for LONG_PRESS_CYC cycles, go to SOFT.
  - SOFT:
    - Asserts sys_rst and waits for btn_level[0]=0, then goes to HOLD (full hold period).
    - A lock drop goes to WAIT_LOCK.
- Precedence: a lock drop beats every other transition in every state.
- sys_rst is a registered output decoded from the next state, so there is no combinational path from inputs to sys_rst.
- Buttons are debounced in every state. Press and release pulses are still produced while sys_rst=1.
- LED:
  - WAIT_LOCK: off.
  - HOLD and SOFT: on.
  - RUN: toggles every HB_DIV cycles, with the divider cleared on entry to RUN.
- Reset mid-operation returns everything to the reset values immediately. There is no partial state.

Decomposition:
- Package board_ctrl_pkg holds:
  - state enum st_e {ST_WAIT_LOCK, ST_HOLD, ST_RUN, ST_SOFT};
  - the default timing constants for 12 MHz.
- Sub-module btn_debounce (single bit, parameter DEBOUNCE_CYC) contains the synchroniser, counter, level and edge pulses. It is instantiated N_BTN times in a generate loop.

Test Plan (bench parameters DEBOUNCE_CYC=8, LOCK_FILTER_CYC=16, RST_HOLD_CYC=4, LONG_PRESS_CYC=50, HB_DIV=10, N_BTN=2):
- Power-up: release rst with pll_locked=1 held → sys_rst=1 for 2+16+4 cycles (±1), then state=RUN and the LED toggles every 10 cycles.
- Lock bounce: toggle pll_locked low for 1 cycle every 10 cycles → the FSM never leaves WAIT_LOCK and sys_rst stays 1.
- Lock loss in RUN: drop pll_locked → sys_rst=1 exactly 3 cycles later (2 sync + 1 register) and state=WAIT_LOCK.
- Debounce: 5-cycle low glitch on btn_n[1] → no pulse. A 20-cycle low → btn_press[1] is a single 1-cycle pulse 2+8 cycles after the falling edge, and btn_release[1] follows after release.
- Long press: hold btn_n[0] low for 70 cycles in RUN → state=SOFT and sys_rst=1. On release → HOLD for 4 cycles, then RUN.
- Async reset asserted during HOLD → all outputs return to their reset values within the same cycle, with no clock edge required.

Source files
------------

// File: rtl/board_reset_ctrl_pkg.sv
// Shared types and default 12 MHz timing for the board reset/button front-end.
package board_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2,
        ST_SOFT      = 2'd3
    } st_e;

    localparam int unsigned DEF_N_BTN           = 1;
    localparam int unsigned DEF_DEBOUNCE_CYC    = 120000;
    localparam int unsigned DEF_LOCK_FILTER_CYC = 1024;
    localparam int unsigned DEF_RST_HOLD_CYC    = 16;
    localparam int unsigned DEF_LONG_PRESS_CYC  = 24000000;
    localparam int unsigned DEF_HB_DIV          = 6000000;

    // Width of a counter that must be able to hold max_val; never below 1 bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/board_reset_ctrl_if.sv
// Board-side signal bundle between the PLL/button pins and the reset controller.
interface board_reset_ctrl_if
    import board_ctrl_pkg::*;
#(
    parameter int unsigned N_BTN = DEF_N_BTN
);
    logic             pll_locked;
    logic [N_BTN-1:0] btn_n;
    logic             sys_rst;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             led_status_n;
    st_e              state;

    modport master (
        output pll_locked, btn_n,
        input  sys_rst, btn_level, btn_press, btn_release, led_status_n, state
    );

    modport slave (
        input  pll_locked, btn_n,
        output sys_rst, btn_level, btn_press, btn_release, led_status_n, state
    );
endinterface

// File: rtl/board_reset_ctrl_debounce.sv
// Purpose: 2-flop synchroniser plus stability counter for one active-low button.
// Latency: level and its press/release pulse change 2+DEBOUNCE_CYC cycles after the pin.
// Backpressure: none; free-running, outputs are always valid.
module btn_debounce
    import board_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);
    localparam int unsigned CW = cnt_width(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYC);

    logic          sync1_n;
    logic          sync2_n;
    logic          pressed;
    logic          differ;
    logic          settle;
    logic [CW-1:0] cnt;

    assign pressed = ~sync2_n;
    assign differ  = (pressed != level);
    assign settle  = differ && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_n       <= 1'b1;
            sync2_n       <= 1'b1;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1_n       <= btn_n;
            sync2_n       <= sync1_n;
            // Pulses are registered alongside level so they line up with its change.
            press_pulse   <= settle && pressed;
            release_pulse <= settle && !pressed;
            if (settle) begin
                level <= pressed;
                cnt   <= '0;
            end else if (differ) begin
                if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/board_reset_ctrl.sv
// Purpose: PLL-lock filtered reset sequencer, button debounce, long-press soft reset, status LED.
// Latency: sys_rst follows a synchronised lock drop by 3 cycles; buttons settle in 2+DEBOUNCE_CYC.
// Backpressure: none; all outputs are registered and always valid.
module board_reset_ctrl
    import board_ctrl_pkg::*;
#(
    parameter int unsigned N_BTN           = DEF_N_BTN,
    parameter int unsigned DEBOUNCE_CYC    = DEF_DEBOUNCE_CYC,
    parameter int unsigned LOCK_FILTER_CYC = DEF_LOCK_FILTER_CYC,
    parameter int unsigned RST_HOLD_CYC    = DEF_RST_HOLD_CYC,
    parameter int unsigned LONG_PRESS_CYC  = DEF_LONG_PRESS_CYC,
    parameter int unsigned HB_DIV          = DEF_HB_DIV
) (
    input  logic               clk,
    input  logic               rst,
    board_reset_ctrl_if.slave  bus
);
    localparam int unsigned LW = cnt_width(LOCK_FILTER_CYC);
    localparam int unsigned HW = cnt_width(RST_HOLD_CYC);
    localparam int unsigned PW = cnt_width(LONG_PRESS_CYC);
    localparam int unsigned BW = cnt_width(HB_DIV);

    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_FILTER_CYC - 1);
    localparam logic [LW-1:0] LOCK_MAX   = LW'(LOCK_FILTER_CYC);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_HOLD_CYC - 1);
    localparam logic [PW-1:0] PRESS_LAST = (LONG_PRESS_CYC > 0) ? PW'(LONG_PRESS_CYC - 1) : '0;
    localparam logic [PW-1:0] PRESS_MAX  = PW'(LONG_PRESS_CYC);
    localparam logic [BW-1:0] HB_LAST    = BW'(HB_DIV - 1);

    st_e              state_q;
    st_e              state_d;
    logic             lock_sync1;
    logic             lock_sync2;
    logic [LW-1:0]    lock_cnt;
    logic [HW-1:0]    hold_cnt;
    logic [PW-1:0]    press_cnt;
    logic [BW-1:0]    hb_cnt;
    logic [BW-1:0]    hb_d;
    logic             sys_rst_q;
    logic             led_n_q;
    logic             led_n_d;
    logic             lock_drop;
    logic             lock_ok;
    logic             hold_done;
    logic             long_press;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_debounce (
            .clk           (clk),
            .rst           (rst),
            .btn_n         (bus.btn_n[i]),
            .level         (btn_level[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i])
        );
    end

    assign lock_drop  = !lock_sync2;
    assign lock_ok    = lock_sync2 && (lock_cnt == LOCK_LAST);
    assign hold_done  = (hold_cnt == HOLD_LAST);
    // >= so a press already long when RUN is entered still triggers.
    assign long_press = (LONG_PRESS_CYC > 0) && btn_level[0] && (press_cnt >= PRESS_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_WAIT_LOCK;
            sys_rst_q  <= 1'b1;
            led_n_q    <= 1'b1;
            hb_cnt     <= '0;
            lock_sync1 <= 1'b0;
            lock_sync2 <= 1'b0;
        end else begin
            state_q    <= state_d;
            sys_rst_q  <= (state_d != ST_RUN);
            led_n_q    <= led_n_d;
            hb_cnt     <= hb_d;
            lock_sync1 <= bus.pll_locked;
            lock_sync2 <= lock_sync1;
        end
    end

    always_comb begin
        state_d = state_q;
        led_n_d = 1'b1;
        hb_d    = '0;
        if (lock_drop) begin
            state_d = ST_WAIT_LOCK;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: if (lock_ok)       state_d = ST_HOLD;
                ST_HOLD:      if (hold_done)     state_d = ST_RUN;
                ST_RUN:       if (long_press)    state_d = ST_SOFT;
                ST_SOFT:      if (!btn_level[0]) state_d = ST_HOLD;
                default:                         state_d = ST_WAIT_LOCK;
            endcase
        end

        case (state_d)
            ST_HOLD, ST_SOFT: led_n_d = 1'b0;
            ST_RUN: begin
                if (state_q != ST_RUN) begin
                    led_n_d = 1'b0;
                end else if (hb_cnt == HB_LAST) begin
                    led_n_d = ~led_n_q;
                end else begin
                    led_n_d = led_n_q;
                    hb_d    = hb_cnt + 1'b1;
                end
            end
            default: led_n_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_cnt  <= '0;
            hold_cnt  <= '0;
            press_cnt <= '0;
        end else begin
            if (state_q == ST_WAIT_LOCK && state_d == ST_WAIT_LOCK && lock_sync2) begin
                if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + 1'b1;
            end else begin
                lock_cnt <= '0;
            end

            if (state_q == ST_HOLD && state_d == ST_HOLD) hold_cnt <= hold_cnt + 1'b1;
            else                                          hold_cnt <= '0;

            if (btn_level[0]) begin
                if (press_cnt != PRESS_MAX) press_cnt <= press_cnt + 1'b1;
            end else begin
                press_cnt <= '0;
            end
        end
    end

    assign bus.sys_rst      = sys_rst_q;
    assign bus.led_status_n = led_n_q;
    assign bus.state        = state_q;
    assign bus.btn_level    = btn_level;
    assign bus.btn_press    = btn_press;
    assign bus.btn_release  = btn_release;
endmodule
